// File: rtl/jtframe_dump_sched.sv
// Debug capture window scheduler: counts frames on VS falling edges and opens
// repeated capture windows from a programmed frame or from the end of ROM download.
module jtframe_dump_sched #(
    parameter int FW = 32,
    parameter int LW = 16,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          downloading,
    input  logic          cfg_mode,
    input  logic [FW-1:0] cfg_start,
    input  logic [LW-1:0] cfg_len,
    input  logic [LW-1:0] cfg_gap,
    input  logic [RW-1:0] cfg_reps,
    output logic [FW-1:0] frame_cnt,
    output logic          dump_on,
    output logic          dump_start,
    output logic          dump_stop,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t        state_r;
    logic          vs_l_r;
    logic          dl_l_r;
    logic [LW-1:0] win_r;
    logic [LW-1:0] gap_r;
    logic [RW-1:0] reps_left_r;
    logic [FW-1:0] cfg_start_r;
    logic [LW-1:0] cfg_len_r;
    logic [LW-1:0] cfg_gap_r;
    logic [RW-1:0] cfg_reps_r;

    logic          vs_fall_s;
    logic          dl_fall_s;
    logic [FW-1:0] frame_nxt_s;

    // A repetition count of zero still produces one window
    function automatic logic [RW-1:0] reps_floor(input logic [RW-1:0] reps);
        return (reps == RW'(0)) ? RW'(1) : reps;
    endfunction

    assign vs_fall_s   = vs_l_r & ~vs;
    assign dl_fall_s   = dl_l_r & ~downloading;
    assign frame_nxt_s = vs_fall_s ? frame_cnt + FW'(1) : frame_cnt;

    // Scheduler state machine, frame counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vs_l_r      <= 1'b0;
            dl_l_r      <= 1'b0;
            win_r       <= LW'(0);
            gap_r       <= LW'(0);
            reps_left_r <= RW'(0);
            cfg_start_r <= FW'(0);
            cfg_len_r   <= LW'(0);
            cfg_gap_r   <= LW'(0);
            cfg_reps_r  <= RW'(0);
            frame_cnt   <= FW'(0);
            dump_on     <= 1'b0;
            dump_start  <= 1'b0;
            dump_stop   <= 1'b0;
            done        <= 1'b0;
        end else begin
            vs_l_r     <= vs;
            dl_l_r     <= downloading;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            frame_cnt  <= downloading ? FW'(0) : frame_nxt_s;
            if (downloading && state_r != ST_IDLE) begin
                // A new download aborts any schedule in progress
                state_r   <= ST_IDLE;
                dump_on   <= 1'b0;
                done      <= 1'b0;
                dump_stop <= dump_on;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!downloading && !cfg_mode) begin
                            cfg_start_r <= cfg_start;
                            cfg_len_r   <= cfg_len;
                            cfg_gap_r   <= cfg_gap;
                            cfg_reps_r  <= cfg_reps;
                            state_r     <= ST_WAIT;
                        end else if (dl_fall_s && cfg_mode) begin
                            cfg_start_r <= cfg_start;
                            cfg_len_r   <= cfg_len;
                            cfg_gap_r   <= cfg_gap;
                            cfg_reps_r  <= cfg_reps;
                            win_r       <= cfg_len;
                            reps_left_r <= reps_floor(cfg_reps);
                            dump_on     <= 1'b1;
                            dump_start  <= 1'b1;
                            state_r     <= ST_ACTIVE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (cfg_start_r == FW'(0) ||
                            (vs_fall_s && frame_nxt_s == cfg_start_r)) begin
                            win_r       <= cfg_len_r;
                            reps_left_r <= reps_floor(cfg_reps_r);
                            dump_on     <= 1'b1;
                            dump_start  <= 1'b1;
                            state_r     <= ST_ACTIVE;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_ACTIVE: begin
                        // A zero-length window is never decremented, so it stays open
                        if (vs_fall_s && win_r != LW'(0)) begin
                            if (win_r == LW'(1)) begin
                                if (reps_left_r == RW'(1)) begin
                                    dump_on   <= 1'b0;
                                    dump_stop <= 1'b1;
                                    done      <= 1'b1;
                                    state_r   <= ST_DONE;
                                end else begin
                                    reps_left_r <= reps_left_r - RW'(1);
                                    if (cfg_gap_r == LW'(0)) begin
                                        win_r <= cfg_len_r;
                                    end else begin
                                        dump_on   <= 1'b0;
                                        dump_stop <= 1'b1;
                                        gap_r     <= cfg_gap_r;
                                        state_r   <= ST_GAP;
                                    end
                                end
                            end else begin
                                win_r <= win_r - LW'(1);
                            end
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                    ST_GAP: begin
                        if (vs_fall_s) begin
                            if (gap_r == LW'(1)) begin
                                win_r      <= cfg_len_r;
                                dump_on    <= 1'b1;
                                dump_start <= 1'b1;
                                state_r    <= ST_ACTIVE;
                            end else begin
                                gap_r <= gap_r - LW'(1);
                            end
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        dump_on <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Bench for jtframe_dump_sched: directed scenarios plus random traffic, checked
// every cycle against a frame-arithmetic model of the capture schedule.
module tb_jtframe_dump_sched;

    localparam int FW = 8;
    localparam int LW = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs;
    logic          downloading;
    logic          cfg_mode;
    logic [FW-1:0] cfg_start;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] cfg_gap;
    logic [RW-1:0] cfg_reps;
    logic [FW-1:0] frame_cnt;
    logic          dump_on;
    logic          dump_start;
    logic          dump_stop;
    logic          done;

    jtframe_dump_sched #(.FW(FW), .LW(LW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .cfg_gap(cfg_gap), .cfg_reps(cfg_reps), .frame_cnt(frame_cnt),
        .dump_on(dump_on), .dump_start(dump_start), .dump_stop(dump_stop),
        .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_stop  = 0;

    // Model: phase 0 = not scheduled, 1 = armed, 2 = schedule running;
    // m_e counts frames since the first window opened.
    int     m_phase = 0;
    longint m_fc = 0;
    longint m_e = 0;
    int     ml_start = 0, ml_len = 0, ml_gap = 0, ml_reps = 1;
    bit     m_vsp = 1'b0, m_dlp = 1'b0;
    bit     e_on = 1'b0, e_start = 1'b0, e_stop = 1'b0, e_done = 1'b0;
    longint e_fc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic latch_cfg();
        ml_start = int'(cfg_start);
        ml_len   = int'(cfg_len);
        ml_gap   = int'(cfg_gap);
        ml_reps  = (cfg_reps == RW'(0)) ? 1 : int'(cfg_reps);
    endtask

    task automatic model_step();
        bit vf, df, on, dn;
        longint p;
        if (rst) begin
            m_phase = 0; m_fc = 0; m_e = 0; m_vsp = 1'b0; m_dlp = 1'b0;
            e_on = 1'b0; e_start = 1'b0; e_stop = 1'b0; e_done = 1'b0; e_fc = 0;
            return;
        end
        vf = m_vsp && !vs;
        df = m_dlp && !downloading;
        m_vsp = vs;
        m_dlp = downloading;
        if (downloading) begin
            m_fc = 0;
            m_phase = 0;
        end else begin
            if (vf) m_fc = (m_fc + 1) % (64'd1 << FW);
            case (m_phase)
                0: begin
                    if (!cfg_mode) begin
                        latch_cfg(); m_phase = 1;
                    end else if (df) begin
                        latch_cfg(); m_phase = 2; m_e = 0;
                    end
                end
                1: begin
                    if (ml_start == 0 || (vf && m_fc == ml_start)) begin
                        m_phase = 2; m_e = 0;
                    end
                end
                default: if (vf) m_e++;
            endcase
        end
        on = 1'b0;
        dn = 1'b0;
        if (m_phase == 2) begin
            if (ml_len == 0) begin
                on = 1'b1;
            end else begin
                p  = ml_len + ml_gap;
                on = (m_e / p) < ml_reps && (m_e % p) < ml_len;
                dn = m_e >= (ml_reps - 1) * p + ml_len;
            end
        end
        e_start = on && !e_on;
        e_stop  = !on && e_on;
        e_on    = on;
        e_done  = dn;
        e_fc    = m_fc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("dump_on", 64'(dump_on), 64'(e_on));
        chk("dump_start", 64'(dump_start), 64'(e_start));
        chk("dump_stop", 64'(dump_stop), 64'(e_stop));
        chk("done", 64'(done), 64'(e_done));
        chk("frame_cnt", 64'(frame_cnt), 64'(e_fc));
        if (dump_start) n_start++;
        if (dump_stop) n_stop++;
    endtask

    task automatic frames(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1;
            repeat (hi) tick();
            vs = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic set_cfg(input int s, input int l, input int g, input int r);
        cfg_start = FW'(s);
        cfg_len   = LW'(l);
        cfg_gap   = LW'(g);
        cfg_reps  = RW'(r);
    endtask

    task automatic restart();
        downloading = 1'b1;
        repeat (2) tick();
        n_start = 0;
        n_stop  = 0;
        downloading = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; downloading = 1'b0; cfg_mode = 1'b0;
        set_cfg(5, 3, 0, 1);
        repeat (3) tick();
        chk("rst_on", 64'(dump_on), 64'd0);
        chk("rst_fc", 64'(frame_cnt), 64'd0);
        rst = 1'b0;

        // Single window: frames [5,8)
        restart();
        frames(10, 2, 2);
        chk("s1_starts", 64'(n_start), 64'd1);
        chk("s1_stops", 64'(n_stop), 64'd1);
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_fc", 64'(frame_cnt), 64'd10);

        // Three windows with gaps: [2,4), [7,9), [12,14)
        set_cfg(2, 2, 3, 3);
        restart();
        frames(15, 2, 2);
        chk("s2_starts", 64'(n_start), 64'd3);
        chk("s2_stops", 64'(n_stop), 64'd3);
        chk("s2_done", 64'(done), 64'd1);

        // Merged windows: gap=0 gives one continuous window [4,8)
        set_cfg(4, 1, 0, 4);
        restart();
        frames(10, 1, 2);
        chk("s3_starts", 64'(n_start), 64'd1);
        chk("s3_stops", 64'(n_stop), 64'd1);
        chk("s3_done", 64'(done), 64'd1);

        // Mode 1: window opens right after the download ends
        cfg_mode = 1'b1;
        set_cfg(0, 2, 0, 1);
        downloading = 1'b1;
        repeat (100) tick();
        downloading = 1'b0;
        tick();
        chk("m1_start", 64'(dump_start), 64'd1);
        chk("m1_fc", 64'(frame_cnt), 64'd0);
        frames(3, 2, 2);
        chk("m1_done", 64'(done), 64'd1);

        // Abort mid-window, then config changes after restart are ignored
        cfg_mode = 1'b0;
        set_cfg(1, 0, 0, 1);
        restart();
        frames(3, 2, 2);
        downloading = 1'b1;
        tick();
        chk("ab_on", 64'(dump_on), 64'd0);
        chk("ab_stop", 64'(dump_stop), 64'd1);
        chk("ab_fc", 64'(frame_cnt), 64'd0);
        set_cfg(1, 2, 0, 1);
        downloading = 1'b0;
        tick();
        set_cfg(9, 7, 0, 1);
        frames(4, 2, 2);
        chk("ab_done", 64'(done), 64'd1);

        // Reset in GAP coinciding with a VS fall
        set_cfg(1, 1, 5, 2);
        restart();
        frames(3, 2, 2);
        vs = 1'b1;
        repeat (2) tick();
        vs = 1'b0;
        rst = 1'b1;
        tick();
        chk("rg_on", 64'(dump_on), 64'd0);
        chk("rg_pulses", 64'(dump_start | dump_stop), 64'd0);
        chk("rg_fc", 64'(frame_cnt), 64'd0);
        rst = 1'b0;

        // Frame counter wrap with an open-ended window
        set_cfg(250, 0, 0, 1);
        restart();
        frames(260, 1, 1);
        chk("wr_fc", 64'(frame_cnt), 64'd4);
        chk("wr_on", 64'(dump_on), 64'd1);

        // Random traffic
        for (int i = 0; i < 12000; i++) begin
            vs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) downloading = ~downloading;
            if ($urandom_range(0, 149) == 0) cfg_mode = ~cfg_mode;
            if ($urandom_range(0, 39) == 0)
                set_cfg($urandom_range(0, 12), $urandom_range(0, 4),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
